// File: rtl/wrd_pkg.sv
// Shared definitions for the wake-word pipeline: lane width, signed lane type and
// the lane-wise max helper. Lane k of a packed vector occupies bits [8k+7:8k].
package wrd_pkg;

  localparam int unsigned BW = 8;

  typedef logic signed [BW-1:0] lane_t;

  // Pure signed compare; on a tie both operands are bit-identical.
  function automatic lane_t lane_max(input lane_t a, input lane_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vec_max.sv
// Combinational lane-wise signed maximum of two packed feature vectors.
module vec_max
  import wrd_pkg::*;
#(
  parameter int unsigned NUM_FILTERS = 8
) (
  input  logic [NUM_FILTERS*BW-1:0] a_i,
  input  logic [NUM_FILTERS*BW-1:0] b_i,
  output logic [NUM_FILTERS*BW-1:0] max_o
);

  // Per-lane signed max, lanes are independent.
  always_comb begin
    max_o = '0;
    for (int k = 0; k < NUM_FILTERS; k++) begin
      max_o[k*BW +: BW] = lane_max(lane_t'(a_i[k*BW +: BW]), lane_t'(b_i[k*BW +: BW]));
    end
  end

endmodule

// File: rtl/max_pool1d.sv
// Temporal max pooling over non-overlapping windows of POOL_LEN time steps.
// A window also closes early on last_i, so a short tail window is emitted as-is.
// Optional feature: define MAX_POOL_LEN_CHECK_EN to add a sticky frame-length
// error flag (err_o) driven by a per-frame step counter.
module max_pool1d
  import wrd_pkg::*;
#(
  parameter int unsigned NUM_FILTERS = 8,
  parameter int unsigned FRAME_LEN   = 50,
  parameter int unsigned POOL_LEN    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_FILTERS*BW-1:0] data_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  output logic                      ready_o,
  output logic [NUM_FILTERS*BW-1:0] data_o,
  output logic                      valid_o,
  output logic                      last_o,
  input  logic                      ready_i
`ifdef MAX_POOL_LEN_CHECK_EN
  ,
  output logic                      err_o
`endif
);

  localparam int unsigned VECTOR_BW = NUM_FILTERS * BW;
  localparam int unsigned CntW      = (POOL_LEN > 1) ? $clog2(POOL_LEN) : 1;
  // An illegal configuration never accepts input rather than pooling incorrectly.
  localparam bit          ParamsOk  = (POOL_LEN >= 2) && (FRAME_LEN >= POOL_LEN);

  logic [CntW-1:0]      win_cnt_q;
  logic [VECTOR_BW-1:0] acc_q;
  logic [VECTOR_BW-1:0] acc_d;
  logic [VECTOR_BW-1:0] max_vec;
  logic [VECTOR_BW-1:0] data_q;
  logic                 valid_q;
  logic                 last_q;
  logic                 in_fire;
  logic                 close_win;

  vec_max #(
    .NUM_FILTERS(NUM_FILTERS)
  ) u_vec_max (
    .a_i  (acc_q),
    .b_i  (data_i),
    .max_o(max_vec)
  );

  // Stall only while an unconsumed result sits in the output register.
  assign ready_o   = (!valid_q || ready_i) && ParamsOk;
  assign in_fire   = valid_i && ready_o;
  assign close_win = in_fire && (last_i || (win_cnt_q == CntW'(POOL_LEN - 1)));
  // First element of a window replaces acc; later ones fold into it.
  assign acc_d     = (win_cnt_q == '0) ? data_i : max_vec;

  // Window accumulation and output register; a close in the same cycle as an
  // output transfer reloads the register and keeps valid high.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      win_cnt_q <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      if (in_fire) begin
        acc_q     <= acc_d;
        win_cnt_q <= close_win ? '0 : win_cnt_q + 1'b1;
      end
      if (close_win) begin
        data_q  <= acc_d;
        last_q  <= last_i;
        valid_q <= 1'b1;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

`ifdef MAX_POOL_LEN_CHECK_EN
  localparam int unsigned StepW = $clog2(FRAME_LEN + 1);

  logic [StepW-1:0] step_cnt_q;
  logic             err_q;
  logic             at_frame_end;

  assign at_frame_end = (step_cnt_q == StepW'(FRAME_LEN - 1));

  // Count accepted steps per frame; flag any mismatch between last_i and the
  // expected frame end. Counter saturates so an overlong frame cannot wrap.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      step_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (in_fire) begin
      if (last_i) begin
        step_cnt_q <= '0;
      end else if (step_cnt_q != StepW'(FRAME_LEN)) begin
        step_cnt_q <= step_cnt_q + 1'b1;
      end
      if (last_i != at_frame_end) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_max_pool1d.sv
// Directed bench for max_pool1d with a scoreboard: tests push hand-computed
// pooled vectors, a monitor pops and compares on every output transfer.
module tb_max_pool1d;

  localparam int unsigned NF  = 2;
  localparam int unsigned FL  = 4;
  localparam int unsigned PL  = 2;
  localparam int unsigned VBW = NF * 8;

  logic           clk     = 1'b0;
  logic           rst_n   = 1'b0;
  logic [VBW-1:0] data_i  = '0;
  logic           valid_i = 1'b0;
  logic           last_i  = 1'b0;
  logic           ready_i = 1'b1;
  logic           ready_o;
  logic [VBW-1:0] data_o;
  logic           valid_o;
  logic           last_o;
`ifdef MAX_POOL_LEN_CHECK_EN
  logic           err_o;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [VBW:0] exp_q[$];
  logic [VBW:0] mon_exp;

  always #5 clk = ~clk;

  max_pool1d #(
    .NUM_FILTERS(NF),
    .FRAME_LEN  (FL),
    .POOL_LEN   (PL)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .last_i (last_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .last_o (last_o),
    .ready_i(ready_i)
`ifdef MAX_POOL_LEN_CHECK_EN
    ,
    .err_o  (err_o)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VBW-1:0] pk(input int l0, input int l1);
    return {8'(l1), 8'(l0)};
  endfunction

  task automatic push_exp(input int l0, input int l1, input bit last);
    exp_q.push_back({last, pk(l0, l1)});
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected output: got last=%0b data=0x%0h, expected none", last_o, data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pooled output {last,data}", {15'b0, last_o, data_o}, {15'b0, mon_exp});
      end
    end
  end

  // Callers start #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input int l0, input int l1, input bit last);
    bit acc;
    int guard;
    guard   = 0;
    data_i  = pk(l0, l1);
    last_i  = last;
    valid_i = 1'b1;
    do begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) begin
      n_checks++;
      n_fails++;
      $display("FAIL send timeout: got ready_o=0 for 200 cycles, expected acceptance");
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_i = 1'b1;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("scoreboard drained", exp_q.size(), 0);
    @(negedge clk);
    check("idle after drain valid_o", valid_o, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("reset valid_o", valid_o, 0);
    check("reset last_o", last_o, 0);
    check("reset data_o", data_o, 0);
    check("reset ready_o", ready_o, 1);
`ifdef MAX_POOL_LEN_CHECK_EN
    check("reset err_o", err_o, 0);
`endif
    @(posedge clk);
    #1;

    // Basic pooling with signed extremes.
    push_exp(5, 7, 1'b0);
    push_exp(-1, 127, 1'b1);
    send(5, 0, 1'b0);
    send(-3, 7, 1'b0);
    @(negedge clk);
    check("basic latency valid_o", valid_o, 1);
    @(posedge clk);
    #1;
    send(-128, 127, 1'b0);
    send(-1, 127, 1'b1);
    @(negedge clk);
    check("basic second valid_o", valid_o, 1);
    check("basic second last_o", last_o, 1);
    @(posedge clk);
    #1;
    drain();
`ifdef MAX_POOL_LEN_CHECK_EN
    check("basic err_o clean frame", err_o, 0);
`endif

    // Odd frame: tail window of one element.
    push_exp(2, 2, 1'b0);
    push_exp(4, 4, 1'b0);
    push_exp(5, 5, 1'b1);
    for (int i = 1; i <= 5; i++) send(i, i, i == 5);
    drain();

    // Backpressure: output held, input stalled, nothing lost.
    push_exp(9, -2, 1'b0);
    push_exp(-5, 6, 1'b1);
    send(3, -2, 1'b0);
    send(9, -8, 1'b0);
    ready_i = 1'b0;
    fork
      send(-5, 4, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall ready_o", ready_o, 0);
          check("stall valid_o", valid_o, 1);
          check("stall data_o", data_o, pk(9, -2));
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    send(-7, 6, 1'b1);
    drain();

    // Bubbles over a 50-step frame: lane0 = i, lane1 = -i.
    for (int i = 1; i < 50; i += 2) push_exp(i, -(i - 1), i == 49);
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(i, -i, i == 49);
    end
    drain();

    // Mid-frame reset: open window with a large value must be discarded.
    push_exp(20, 20, 1'b0);
    send(10, 10, 1'b0);
    send(20, 20, 1'b0);
    send(100, 100, 1'b0);
    do_reset();
    @(negedge clk);
    check("post-reset valid_o", valid_o, 0);
    check("post-reset ready_o", ready_o, 1);
    @(posedge clk);
    #1;
    push_exp(-5, -5, 1'b1);
    send(-5, -5, 1'b0);
    send(-9, -9, 1'b1);
    drain();

`ifdef MAX_POOL_LEN_CHECK_EN
    // Length check: last_i on the 3rd step of a 4-step frame.
    do_reset();
    push_exp(2, 2, 1'b0);
    push_exp(3, 3, 1'b1);
    send(1, 1, 1'b0);
    send(2, 2, 1'b0);
    send(3, 3, 1'b1);
    @(negedge clk);
    check("length err_o set", err_o, 1);
    @(posedge clk);
    #1;
    drain();
    repeat (3) begin
      @(negedge clk);
      check("length err_o sticky", err_o, 1);
    end
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("length err_o cleared", err_o, 0);
    @(posedge clk);
    #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
